// File: rtl/pipe_pkg.sv
// pipe_pkg: scoreboard entry type and shared constants (is_div field only with DIV_TRACK_EN)
package pipe_pkg;
  localparam int DIV_CNT_W = 4;
  localparam int DEST_MAX_W = 8;
  localparam logic [2:0] FWD_REGFILE = 3'd0;
  typedef struct packed {
    logic valid;
    logic [DEST_MAX_W-1:0] dest;
    logic writes;
    logic mem_to_reg;
`ifdef DIV_TRACK_EN
    logic is_div;
`endif
  } sb_entry_t;
endpackage

// File: rtl/sb_stage_reg.sv
// sb_stage_reg: one scoreboard stage entry register with synchronous clear
module sb_stage_reg
  import pipe_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  sb_entry_t d,
  output sb_entry_t q
);
  always_ff @(posedge clock) q <= reset ? '0 : d;
endmodule

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: stall/flush and forwarding over a DEPTH-stage producer chain; DIV_TRACK_EN adds divide tracking
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_ID_W = 5,
  parameter int DEPTH = 3,
  parameter int DIV_LAT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [REG_ID_W-1:0] issue_rs,
  input  logic [REG_ID_W-1:0] issue_rt,
  input  logic [REG_ID_W-1:0] issue_dest,
  input  logic                issue_writes,
  input  logic                issue_mem_to_reg,
  input  logic                issue_is_div,
  input  logic                issue_mf_op,
  input  logic                kill_d,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_e,
  output logic [2:0]          fwd_a,
  output logic [2:0]          fwd_b,
  output logic                div_busy
);
  sb_entry_t ent [1:DEPTH];
  sb_entry_t new_ent;
  logic load_use, hazard, stall, fire;
  function automatic logic hit(input sb_entry_t e, input logic [REG_ID_W-1:0] s);
    return e.valid && e.writes && e.dest == DEST_MAX_W'(s) && s != '0;
  endfunction
  for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
    if (i == 1) begin : g_head
      sb_stage_reg u_reg (.clock(clock), .reset(reset), .d(new_ent), .q(ent[i]));
    end else begin : g_tail
      sb_stage_reg u_reg (.clock(clock), .reset(reset), .d(ent[i-1]), .q(ent[i]));
    end
  end
  assign load_use = ent[1].mem_to_reg && (hit(ent[1], issue_rs) || hit(ent[1], issue_rt));
`ifdef DIV_TRACK_EN
  logic [DIV_CNT_W-1:0] div_cnt;
  logic div_in_flight;
  always_comb begin
    div_in_flight = 1'b0;
    for (int k = 1; k <= DEPTH; k++) div_in_flight = div_in_flight | ent[k].is_div;
  end
  assign div_busy = div_cnt != '0;
  assign hazard = load_use || (issue_is_div && div_busy) || (issue_mf_op && (div_busy || div_in_flight));
  always_ff @(posedge clock)
    div_cnt <= reset ? '0 : (fire && issue_is_div) ? DIV_CNT_W'(DIV_LAT) : div_busy ? div_cnt - DIV_CNT_W'(1) : div_cnt;
`else
  logic div_unused;
  assign div_unused = issue_is_div ^ issue_mf_op;
  assign div_busy = 1'b0;
  assign hazard = load_use;
`endif
  assign stall = issue_valid && !kill_d && hazard;
  assign fire = issue_valid && !kill_d && !hazard;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;
  always_comb begin
    new_ent = '0;
    new_ent.valid = fire;
    new_ent.dest = fire ? DEST_MAX_W'(issue_dest) : '0;
    new_ent.writes = fire && issue_writes;
    new_ent.mem_to_reg = fire && issue_mem_to_reg;
`ifdef DIV_TRACK_EN
    new_ent.is_div = fire && issue_is_div;
`endif
  end
  always_comb begin
    fwd_a = FWD_REGFILE;
    fwd_b = FWD_REGFILE;
    for (int k = DEPTH; k >= 1; k--) begin
      fwd_a = hit(ent[k], issue_rs) ? 3'(k) : fwd_a;
      fwd_b = hit(ent[k], issue_rt) ? 3'(k) : fwd_b;
    end
  end
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed scoreboard-queue bench for pipe_scoreboard (DIV_TRACK_EN optional)
module tb_pipe_scoreboard;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic issue_valid = 1'b0;
  logic [4:0] issue_rs = '0, issue_rt = '0, issue_dest = '0;
  logic issue_writes = 1'b0, issue_mem_to_reg = 1'b0, issue_is_div = 1'b0, issue_mf_op = 1'b0, kill_d = 1'b0;
  logic stall_f, stall_d, flush_e, div_busy;
  logic [2:0] fwd_a, fwd_b;
`ifdef DIV_TRACK_EN
  localparam logic DIV_ON = 1'b1;
`else
  localparam logic DIV_ON = 1'b0;
`endif
  localparam logic [4:0] WR = 5'b10000, LD = 5'b01000, DV = 5'b00100, MF = 5'b00010, KL = 5'b00001;
  typedef struct {
    string tag;
    logic st;
    logic [2:0] fa;
    logic [2:0] fb;
    logic busy;
  } exp_t;
  exp_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  pipe_scoreboard #(.REG_ID_W(5), .DEPTH(3), .DIV_LAT(4)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_dest(issue_dest), .issue_writes(issue_writes), .issue_mem_to_reg(issue_mem_to_reg),
    .issue_is_div(issue_is_div), .issue_mf_op(issue_mf_op), .kill_d(kill_d), .stall_f(stall_f),
    .stall_d(stall_d), .flush_e(flush_e), .fwd_a(fwd_a), .fwd_b(fwd_b), .div_busy(div_busy)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask
  task automatic step(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] dest, input logic [4:0] fl, input logic [2:0] fa,
                      input logic [2:0] fb, input logic st, input logic busy);
    exp_t e;
    issue_valid = v;
    issue_rs = rs;
    issue_rt = rt;
    issue_dest = dest;
    {issue_writes, issue_mem_to_reg, issue_is_div, issue_mf_op, kill_d} = fl;
    exp_q.push_back('{tag, st, fa, fb, busy});
    @(negedge clock);
    e = exp_q.pop_front();
    check({e.tag, ".stall_f"}, 8'(stall_f), 8'(e.st));
    check({e.tag, ".stall_d"}, 8'(stall_d), 8'(e.st));
    check({e.tag, ".flush_e"}, 8'(flush_e), 8'(e.st));
    check({e.tag, ".fwd_a"}, 8'(fwd_a), 8'(e.fa));
    check({e.tag, ".fwd_b"}, 8'(fwd_b), 8'(e.fb));
    check({e.tag, ".div_busy"}, 8'(div_busy), 8'(e.busy));
    @(posedge clock);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    step("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("alu0", 1, 1, 2, 5, WR, 0, 0, 0, 0);
    step("alu1", 1, 5, 0, 6, WR, 1, 0, 0, 0);
    step("alu2", 1, 5, 5, 5, WR, 2, 2, 0, 0);
    step("alu3", 1, 5, 6, 7, 0, 1, 2, 0, 0);
    step("alu4", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("alu5", 1, 5, 6, 0, 0, 3, 0, 0, 0);
    step("lu0", 1, 0, 0, 8, WR | LD, 0, 0, 0, 0);
    step("lu1", 1, 0, 8, 9, WR, 0, 1, 1, 0);
    step("lu2", 1, 0, 8, 9, WR, 0, 2, 0, 0);
    step("lu3", 1, 9, 8, 0, 0, 1, 3, 0, 0);
    step("z0", 1, 0, 0, 0, WR | LD, 0, 0, 0, 0);
    step("z1", 1, 0, 0, 3, 0, 0, 0, 0, 0);
    step("k0", 1, 0, 0, 8, WR | LD, 0, 0, 0, 0);
    step("k1", 1, 0, 8, 9, WR | KL, 0, 1, 0, 0);
    step("k2", 1, 9, 8, 0, 0, 0, 2, 0, 0);
    step("r0", 1, 0, 0, 11, WR | DV, 0, 0, 0, 0);
    step("r1", 1, 0, 0, 12, WR, 0, 0, 0, DIV_ON);
    step("r2", 1, 0, 0, 13, WR, 0, 0, 0, DIV_ON);
    reset = 1'b1;
    step("r3", 1, 13, 11, 14, WR, 1, 3, 0, DIV_ON);
    reset = 1'b0;
    step("r4", 1, 13, 14, 0, MF, 0, 0, 0, 0);
    if (DIV_ON) begin
      step("d0", 1, 0, 0, 0, DV, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) step($sformatf("d_mf%0d", i), 1, 0, 0, 0, MF, 0, 0, 1, 1);
      step("d5", 1, 0, 0, 0, MF, 0, 0, 0, 0);
      step("d6", 1, 0, 0, 0, DV, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) step($sformatf("d_div%0d", i), 1, 0, 0, 0, DV, 0, 0, 1, 1);
      step("d11", 1, 0, 0, 0, DV, 0, 0, 0, 0);
      step("d12", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end else begin
      step("nd0", 1, 0, 0, 0, DV, 0, 0, 0, 0);
      step("nd1", 1, 0, 0, 0, DV, 0, 0, 0, 0);
      step("nd2", 1, 0, 0, 0, MF, 0, 0, 0, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
